// File: rtl/sdp_ram_fifo_ctrl_if.sv
// rtl/sdp_ram_fifo_ctrl_if.sv - push/pop and RAM-control bundle for sdp_ram_fifo_ctrl
interface sdp_ram_fifo_ctrl_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic          clr;
   logic          push;
   logic [DW-1:0] push_data;
   logic          pop;
   logic [DW-1:0] pop_data;
   logic          pop_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   logic          ram_ce;
   logic          ram_we;
   logic          ram_re;
   logic [AW-1:0] ram_adr_a;
   logic [AW-1:0] ram_adr_b;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   // Parent side: producer/consumer plus the external RAM read data
   modport master (
      output clr, push, push_data, pop, ram_dout,
      input  pop_data, pop_valid, full, empty, almost_full, count,
             overflow, underflow, ram_ce, ram_we, ram_re,
             ram_adr_a, ram_adr_b, ram_din
   );

   modport slave (
      input  clr, push, push_data, pop, ram_dout,
      output pop_data, pop_valid, full, empty, almost_full, count,
             overflow, underflow, ram_ce, ram_we, ram_re,
             ram_adr_a, ram_adr_b, ram_din
   );
endinterface

// File: rtl/sdp_ram_fifo_ctrl.sv
// rtl/sdp_ram_fifo_ctrl.sv - circular-buffer FIFO controller for an external simple dual-port RAM
module sdp_ram_fifo_ctrl #(
   parameter int DW       = 8,
   parameter int AW       = 8,
   parameter int AF_LEVEL = (2**AW) - 2
) (
   input logic                clk,
   input logic                nrst,
   sdp_ram_fifo_ctrl_if.slave f
);
   localparam int          DEPTH   = 2**AW;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count_q;
   logic [AW:0]   count_nxt;
   logic          pop_valid_q;
   logic          overflow_q;
   logic          underflow_q;
   logic          full_w;
   logic          empty_w;
   logic          push_acc;
   logic          pop_acc;

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);

   // Gating with nrst keeps every RAM strobe low while reset is held,
   // even though the register flags already read as empty.
   assign push_acc = nrst & f.push & ~full_w  & ~f.clr;
   assign pop_acc  = nrst & f.pop  & ~empty_w & ~f.clr;

   always_comb begin
      count_nxt = count_q;
      case ({push_acc, pop_acc})
         2'b10:   count_nxt = count_q + 1'b1;
         2'b01:   count_nxt = count_q - 1'b1;
         default: count_nxt = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wptr        <= '0;
         rptr        <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (f.clr) begin
         wptr        <= '0;
         rptr        <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_acc)
            wptr <= wptr + 1'b1;
         if (pop_acc)
            rptr <= rptr + 1'b1;
         count_q     <= count_nxt;
         pop_valid_q <= pop_acc;
         if (f.push && full_w)
            overflow_q <= 1'b1;
         if (f.pop && empty_w)
            underflow_q <= 1'b1;
      end
   end

   assign f.ram_we      = push_acc;
   assign f.ram_re      = pop_acc;
   assign f.ram_ce      = push_acc | pop_acc;
   assign f.ram_adr_a   = wptr;
   assign f.ram_adr_b   = rptr;
   assign f.ram_din     = f.push_data;

   assign f.pop_data    = f.ram_dout;
   assign f.pop_valid   = pop_valid_q;
   assign f.full        = full_w;
   assign f.empty       = empty_w;
   assign f.almost_full = (count_q >= AF_C);
   assign f.count       = count_q;
   assign f.overflow    = overflow_q;
   assign f.underflow   = underflow_q;
endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// tb/tb_sdp_ram_fifo_ctrl.sv - scoreboard bench for sdp_ram_fifo_ctrl with a DEPTH=4 RAM model
module tb_sdp_ram_fifo_ctrl;
   localparam int DW = 8;
   localparam int AW = 2;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   sdp_ram_fifo_ctrl_if #(.DW(DW), .AW(AW)) f ();

   sdp_ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk  (clk),
      .nrst (nrst),
      .f    (f)
   );

   // Registered-read RAM standing in for the parent's simple_dual_port_ram
   logic [DW-1:0] mem [4];
   always @(posedge clk) begin
      if (f.ram_ce && f.ram_we)
         mem[f.ram_adr_a] <= f.ram_din;
      if (f.ram_ce && f.ram_re)
         f.ram_dout <= mem[f.ram_adr_b];
   end

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (f.pop_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_valid_unexpected actual=%0h required=none", f.pop_data);
         end else begin
            chk("pop_data", 32'(f.pop_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // Drive one cycle's inputs just after the edge; return mid-cycle for checks
   task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q, input logic c);
      @(posedge clk);
      #1;
      f.push      = p;
      f.push_data = d;
      f.pop       = q;
      f.clr       = c;
      #2;
   endtask

   initial begin
      #50000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      nrst        = 1'b0;
      f.push      = 1'b1;
      f.push_data = 8'hAA;
      f.pop       = 1'b1;
      f.clr       = 1'b0;
      #3;
      chk("rst_count", 32'(f.count), 0);
      chk("rst_empty", 32'(f.empty), 1);
      chk("rst_full", 32'(f.full), 0);
      chk("rst_af", 32'(f.almost_full), 0);
      chk("rst_pop_valid", 32'(f.pop_valid), 0);
      chk("rst_ovf", 32'(f.overflow), 0);
      chk("rst_udf", 32'(f.underflow), 0);
      chk("rst_ce", 32'(f.ram_ce), 0);
      chk("rst_we", 32'(f.ram_we), 0);
      chk("rst_re", 32'(f.ram_re), 0);
      chk("rst_adr_a", 32'(f.ram_adr_a), 0);
      f.push = 1'b0;
      f.pop  = 1'b0;
      @(negedge clk);
      nrst = 1'b1;

      // Fill 2,3,4,5 then drain
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'(2 + i), 1'b0, 1'b0);
         chk("fill_we", 32'(f.ram_we), 1);
         chk("fill_adr_a", 32'(f.ram_adr_a), 32'(i));
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fill_full", 32'(f.full), 1);
      chk("fill_count", 32'(f.count), 4);
      chk("fill_af", 32'(f.almost_full), 1);
      chk("drain_adr_b0", 32'(f.ram_adr_b), 0);
      exp_q.push_back(8'd2);
      for (int i = 1; i < 4; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_re", 32'(f.ram_re), 1);
         chk("drain_adr_b", 32'(f.ram_adr_b), 32'(i));
         exp_q.push_back(8'(2 + i));
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("drain_empty", 32'(f.empty), 1);
      chk("drain_count", 32'(f.count), 0);

      // Wrap-around: 1..6 with pops interleaved after the third push
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 8'(1 + i), 1'b0, 1'b0);
         chk("wrap_adr_a", 32'(f.ram_adr_a), 32'(i));
      end
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 8'(4 + k), 1'b1, 1'b0);
         chk("wrap_adr_a_mix", 32'(f.ram_adr_a), 32'((3 + k) % 4));
         chk("wrap_count", 32'(f.count), 3);
         exp_q.push_back(8'(1 + k));
      end
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("wrap_adr_b", 32'(f.ram_adr_b), 32'((3 + k) % 4));
         exp_q.push_back(8'(4 + k));
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("wrap_empty", 32'(f.empty), 1);

      // Simultaneous push/pop at count 2 (pointers both at 2)
      cyc(1'b1, 8'd10, 1'b0, 1'b0);
      chk("sim_adr_a0", 32'(f.ram_adr_a), 2);
      cyc(1'b1, 8'd11, 1'b0, 1'b0);
      cyc(1'b1, 8'd12, 1'b1, 1'b0);
      chk("sim_count_before", 32'(f.count), 2);
      chk("sim_ce", 32'(f.ram_ce), 1);
      chk("sim_we", 32'(f.ram_we), 1);
      chk("sim_re", 32'(f.ram_re), 1);
      chk("sim_adr_a", 32'(f.ram_adr_a), 0);
      chk("sim_adr_b", 32'(f.ram_adr_b), 2);
      exp_q.push_back(8'd10);
      cyc(1'b1, 8'd13, 1'b0, 1'b0);
      chk("sim_count_after", 32'(f.count), 2);
      chk("sim_adr_a_adv", 32'(f.ram_adr_a), 1);
      cyc(1'b1, 8'd14, 1'b0, 1'b0);

      // Full + push + pop: only the pop goes through
      cyc(1'b1, 8'd99, 1'b1, 1'b0);
      chk("fpp_full", 32'(f.full), 1);
      chk("fpp_we", 32'(f.ram_we), 0);
      chk("fpp_re", 32'(f.ram_re), 1);
      chk("fpp_adr_b", 32'(f.ram_adr_b), 3);
      exp_q.push_back(8'd11);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fpp_count", 32'(f.count), 3);
      chk("fpp_ovf", 32'(f.overflow), 1);
      exp_q.push_back(8'd12);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      exp_q.push_back(8'd13);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      exp_q.push_back(8'd14);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("fpp_empty", 32'(f.empty), 1);

      // Pop while empty, then flush
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_re", 32'(f.ram_re), 0);
      chk("udf_ce", 32'(f.ram_ce), 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("udf_flag", 32'(f.underflow), 1);
      chk("udf_pop_valid", 32'(f.pop_valid), 0);
      chk("udf_ovf_sticky", 32'(f.overflow), 1);
      cyc(1'b1, 8'd55, 1'b0, 1'b1);
      chk("clr_we", 32'(f.ram_we), 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("clr_udf", 32'(f.underflow), 0);
      chk("clr_ovf", 32'(f.overflow), 0);
      chk("clr_count", 32'(f.count), 0);
      cyc(1'b1, 8'd7, 1'b0, 1'b0);
      chk("clr_adr_a", 32'(f.ram_adr_a), 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("clr_adr_b", 32'(f.ram_adr_b), 0);
      exp_q.push_back(8'd7);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset while a pop result is in flight
      cyc(1'b1, 8'd8, 1'b0, 1'b0);
      chk("ar_adr_a", 32'(f.ram_adr_a), 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ar_adr_b", 32'(f.ram_adr_b), 1);
      cyc(1'b1, 8'd77, 1'b0, 1'b0);
      chk("ar_pop_valid_pending", 32'(f.pop_valid), 1);
      nrst = 1'b0;
      #1;
      chk("ar_pop_valid", 32'(f.pop_valid), 0);
      chk("ar_count", 32'(f.count), 0);
      chk("ar_we", 32'(f.ram_we), 0);
      @(negedge clk);
      f.push = 1'b0;
      nrst   = 1'b1;
      cyc(1'b1, 8'd9, 1'b0, 1'b0);
      chk("ar_push_adr_a", 32'(f.ram_adr_a), 0);
      chk("ar_push_we", 32'(f.ram_we), 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ar_pop_adr_b", 32'(f.ram_adr_b), 0);
      exp_q.push_back(8'd9);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sdp_ram_fifo_ctrl.md
# sdp_ram_fifo_ctrl

FIFO controller that sequences one `simple_dual_port_ram` instance (8-bit data, 8-bit address, write port A, read port B) as a circular buffer. It converts a push/pop interface into the RAM's `ce`/`we`/`re`/`adr_a`/`adr_b`/`din` controls, and tracks fill level, full/empty, almost-full and error flags. It sits between a producer/consumer pair and the RAM; the RAM instance lives outside this block in the parent.

## Interface
- `DW`, default 8: data width; must match the RAM.
- `AW`, default 8: address width; depth `DEPTH = 2**AW`.
- `AF_LEVEL`, default `DEPTH-2`: `almost_full` threshold, in entries.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `nrst`, in, 1: asynchronous, active-low reset.
- `clr`, in, 1: synchronous flush.
- `push`, in, 1: write request.
- `push_data`, in, DW: write data.
- `pop`, in, 1: read request.
- `pop_data`, out, DW: read data; equals `ram_dout`.
- `pop_valid`, out, 1: `pop_data` is valid this cycle.
- `full`, out, 1: count == DEPTH.
- `empty`, out, 1: count == 0.
- `almost_full`, out, 1: count >= AF_LEVEL.
- `count`, out, AW+1: number of stored entries, 0..DEPTH.
- `overflow`, out, 1: sticky; set by a push while full.
- `underflow`, out, 1: sticky; set by a pop while empty.
- `ram_ce`, out, 1: RAM chip enable.
- `ram_we`, out, 1: RAM write enable.
- `ram_re`, out, 1: RAM read enable.
- `ram_adr_a`, out, AW: RAM write address.
- `ram_adr_b`, out, AW: RAM read address.
- `ram_din`, out, DW: RAM write data.
- `ram_dout`, in, DW: RAM read data; registered, valid one cycle after `ram_re`.

## Operation
- **State:**
  - `wptr`, `rptr`: AW bits each; wrap modulo DEPTH, so DEPTH-1 → 0.
  - `count`: AW+1 bits.
  - `pop_valid`: 1-bit register.
  - `overflow`, `underflow`: sticky registers.
- **Acceptance:**
  - push_acc = push & !full & !clr.
  - pop_acc = pop & !empty & !clr.
  - Both are evaluated on the registered flags, so same-cycle push and pop do not bypass each other.
  - Full + push + pop: only the pop is accepted.
  - Empty + push + pop: only the push is accepted.
- **RAM drive (combinational):**
  - `ram_we` = push_acc; `ram_adr_a` = wptr; `ram_din` = push_data.
  - `ram_re` = pop_acc; `ram_adr_b` = rptr.
  - `ram_ce` = push_acc | pop_acc.
  - While `ram_we` is low, `ram_adr_a` and `ram_din` still reflect wptr and push_data.
- **Updates:**
  - wptr += push_acc; rptr += pop_acc.
  - count += push_acc − pop_acc; it stays unchanged when both are accepted.
- **Same-address hazard:** read and write at the same address in one cycle cannot occur. When wptr == rptr, the FIFO is either empty (pop rejected) or full (push rejected).
- **Errors:**
  - overflow ← 1 on push & full.
  - underflow ← 1 on pop & empty.
  - Both cleared only by `nrst` or `clr`.
- **Flush (`clr`):** takes priority over push and pop. On the next edge, pointers, count, `pop_valid` and errors go to 0. The RAM contents are not touched.

## Timing
- **Reset values (immediate on `nrst` low):**
  - wptr = rptr = 0, count = 0.
  - empty = 1, full = 0, almost_full = 0 (AF_LEVEL > 0).
  - pop_valid = 0, overflow = underflow = 0.
  - All `ram_*` controls = 0, because the acceptance terms are gated off during reset.
- **Read latency:** pop accepted in cycle N → `pop_valid` = 1 and `pop_data` valid in cycle N+1. Back-to-back pops give one datum per cycle.
- **Write-to-read:** push in cycle N → `empty` falls at edge N+1 → earliest pop in cycle N+1 → data in cycle N+2.
- **Flag timing:** `full`, `empty`, `almost_full` are decoded from the registered count and change at the edge after the causing push or pop.
- **Reset mid-operation:** a pending `pop_valid` is dropped and no RAM write is issued in the reset cycle.
- `ram_dout` is not sampled internally; `pop_data` is a wire.

## Test plan
- **Reset, then fill/drain (AW=2, DEPTH=4):** push 2, 3, 4, 5 on consecutive cycles, then pop four times.
  - `ram_adr_a` = 0, 1, 2, 3.
  - `full` = 1 and count = 4 after the 4th push.
  - `pop_data` = 2, 3, 4, 5, each one cycle after its pop.
  - `empty` = 1 at the end.
- **Wrap-around (AW=2):** push 6 entries, interleaving pops after the 3rd push.
  - `ram_adr_a` wraps 3 → 0.
  - Output order is 1..6 with no loss.
- **Simultaneous push/pop at count = 2:** count stays 2, both pointers advance, `ram_ce` = 1 with `ram_we` = `ram_re` = 1.
- **Full + push + pop:** push rejected (`ram_we` = 0), pop accepted, count → 3, `overflow` = 1.
- **Empty + pop:** `ram_re` = 0, `pop_valid` stays 0, `underflow` = 1. A following `clr` clears `underflow` and the pointers.
- **Async reset mid-stream:** assert `nrst` low between edges while a pop is in flight.
  - `pop_valid` and count go to 0 immediately.
  - Push 9 after release → the first pop returns 9 from address 0.
